chacha20_keystream_reader: RTL and testbench

- Consumer side of the 64-byte keystream buffer filled by the concatenator/serialiser path.
- On each block-ready indication it snapshots the keystream bytes. It then reads them out one per accepted data byte and XORs them with a streaming plaintext or ciphertext byte channel.
- It requests the next block from the block function when the current one is exhausted and tracks the 32-bit block counter for the message.
- Sits between Concat_Serialiser_TOP/Block_Function and the plaintext source / ciphertext sink.

---
 rtl/chacha20_keystream_reader_if.sv | 25 ++
 rtl/chacha20_keystream_reader.sv | 149 ++++++++++++++
 tb/tb_chacha20_keystream_reader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chacha20_keystream_reader_if.sv
// Byte-stream handshake bundle for the keystream reader: the plaintext or
// ciphertext source feeds in_*, and the sink drains out_*.
// The master modport is the environment side and the slave modport is the reader side.
interface chacha20_keystream_reader_if #(
    parameter int DATA_SIZE = 8
);
    logic [DATA_SIZE-1:0] in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_last;
    logic                 out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/chacha20_keystream_reader.sv
// ChaCha20 keystream reader.
// - Snapshots a 64-byte keystream block when the buffer reports full.
// - XORs the snapshot byte-by-byte with the data stream.
// - Requests the next block when the current one is used up.
// - Tracks the 32-bit block counter for the message.
// Optional build macro CHACHA_KS_ZEROIZE_EN: wipes each keystream byte after use,
// and wipes the whole snapshot when the message ends or the reader enters ERROR.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no message; waiting for start
// WAIT_KS | block requested; waiting for ks_full to latch the buffer
// STREAM  | XORing data bytes with the latched block
// ERROR   | counter would wrap; only the pending output may drain
module chacha20_keystream_reader #(
    parameter int DATA_SIZE = 8,
    parameter int NO_REG    = 64,
    parameter int CTR_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [CTR_WIDTH-1:0]             init_counter,
    input  logic [NO_REG-1:0][DATA_SIZE-1:0] ks_bytes,
    input  logic                             ks_full,
    output logic                             ks_req,
    output logic [CTR_WIDTH-1:0]             block_counter,
    output logic                             busy,
    output logic                             ctr_overflow,
    chacha20_keystream_reader_if.slave       stream
);
    localparam int IDX_W = $clog2(NO_REG);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NO_REG - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_KS = 2'd1;
    localparam logic [1:0] S_STREAM  = 2'd2;
    localparam logic [1:0] S_ERROR   = 2'd3;

`ifdef CHACHA_KS_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    logic [1:0]                       state;
    logic [IDX_W-1:0]                 idx;
    logic [NO_REG-1:0][DATA_SIZE-1:0] ks_buf;
    logic [DATA_SIZE-1:0]             out_data_q;
    logic                             out_valid_q;
    logic                             out_last_q;
    logic                             in_ready_c;
    logic                             xfer;
    logic                             ctr_max;
    logic                             blk_end;
    logic                             msg_end;
    logic                             ovf_end;

    assign in_ready_c = (state == S_STREAM) && (!out_valid_q || stream.out_ready);
    assign xfer       = stream.in_valid && in_ready_c;
    assign ctr_max    = &block_counter;
    assign msg_end    = xfer && stream.in_last;
    assign blk_end    = xfer && !stream.in_last && (idx == IDX_LAST);
    assign ovf_end    = blk_end && ctr_max;

    assign stream.in_ready  = in_ready_c;
    assign stream.out_data  = out_data_q;
    assign stream.out_valid = out_valid_q;
    assign stream.out_last  = out_last_q;
    assign busy             = (state != S_IDLE);

    // Sequencing: state, byte index, block counter, request pulse, sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            idx           <= '0;
            block_counter <= '0;
            ks_req        <= 1'b0;
            ctr_overflow  <= 1'b0;
        end else begin
            ks_req <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        block_counter <= init_counter;
                        ks_req        <= 1'b1;
                        state         <= S_WAIT_KS;
                    end
                end
                S_WAIT_KS: begin
                    if (ks_full) begin
                        idx   <= '0;
                        state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (msg_end) begin
                        // The message ends early, so the counter saturates instead of flagging overflow.
                        if (!ctr_max) block_counter <= block_counter + 1'b1;
                        idx   <= '0;
                        state <= S_IDLE;
                    end else if (ovf_end) begin
                        ctr_overflow <= 1'b1;
                        state        <= S_ERROR;
                    end else if (blk_end) begin
                        block_counter <= block_counter + 1'b1;
                        ks_req        <= 1'b1;
                        idx           <= '0;
                        state         <= S_WAIT_KS;
                    end else if (xfer) begin
                        idx <= idx + 1'b1;
                    end
                end
                S_ERROR: begin
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output register: one-cycle XOR result; holds while the sink stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (xfer) begin
            out_data_q  <= stream.in_data ^ ks_buf[idx];
            out_valid_q <= 1'b1;
            out_last_q  <= stream.in_last;
        end else if (stream.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    // Keystream snapshot: latch on full in WAIT_KS; optionally wipe consumed bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ks_buf <= '0;
        end else if (state == S_WAIT_KS && ks_full) begin
            ks_buf <= ks_bytes;
        end else if (ZEROIZE && (msg_end || ovf_end)) begin
            ks_buf <= '0;
        end else if (ZEROIZE && xfer) begin
            ks_buf[idx] <= '0;
        end
    end
endmodule

// File: tb/tb_chacha20_keystream_reader.sv
// Self-checking bench for chacha20_keystream_reader.
// - A keystream provider answers each ks_req with a fresh random block.
// - The driver pushes the expected XOR bytes into a scoreboard queue.
// - The monitor pops and compares each byte the sink accepts.
module tb_chacha20_keystream_reader;
    localparam int NB = 64;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [31:0]         init_counter = '0;
    logic [NB-1:0][7:0]  ks_bytes = '0;
    logic                ks_full = 1'b0;
    logic                ks_req;
    logic [31:0]         block_counter;
    logic                busy;
    logic                ctr_overflow;

    chacha20_keystream_reader_if #(.DATA_SIZE(8)) stream_if();

    chacha20_keystream_reader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .init_counter  (init_counter),
        .ks_bytes      (ks_bytes),
        .ks_full       (ks_full),
        .ks_req        (ks_req),
        .block_counter (block_counter),
        .busy          (busy),
        .ctr_overflow  (ctr_overflow),
        .stream        (stream_if)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  ks_mem [0:7][0:NB-1];
    logic [31:0] exp_base = '0;
    int          req_idx = 0;
    int          ks_req_cnt = 0;
    bit          ks_mode_incr = 1'b0;
    logic [8:0]  exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ks_req"}, ks_req, 0);
        chk({tag, "_block_counter"}, block_counter, 0);
        chk({tag, "_in_ready"}, stream_if.in_ready, 0);
        chk({tag, "_out_data"}, stream_if.out_data, 0);
        chk({tag, "_out_valid"}, stream_if.out_valid, 0);
        chk({tag, "_out_last"}, stream_if.out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ctr_overflow"}, ctr_overflow, 0);
    endtask

    // Keystream source: answer each request with a new block after a short random delay.
    initial begin : ks_provider
        int slot;
        forever begin
            @(negedge clk);
            if (rst && ks_req) begin
                slot = req_idx & 7;
                ks_req_cnt++;
                chk("ks_req_counter", block_counter, exp_base + 32'(req_idx));
                ks_full = 1'b0;
                for (int i = 0; i < NB; i++)
                    ks_mem[slot][i] = ks_mode_incr ? 8'(i) : 8'($urandom);
                @(negedge clk);
                chk("ks_req_single_pulse", ks_req, 0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                for (int i = 0; i < NB; i++) ks_bytes[i] = ks_mem[slot][i];
                ks_full = 1'b1;
                req_idx = req_idx + 1;
            end
        end
    end

    // Scoreboard monitor: compare every accepted output byte; check stalled outputs stay stable.
    initial begin : monitor
        logic       prev_stall;
        logic [8:0] prev_word;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", stream_if.out_valid, 1);
                    chk("hold_word", {stream_if.out_last, stream_if.out_data}, prev_word);
                end
                if (stream_if.out_valid && !stream_if.out_ready)
                    chk("stall_in_ready", stream_if.in_ready, 0);
                if (stream_if.out_valid && stream_if.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL out_unexpected actual=0x%0h expected=none t=%0t",
                                 {stream_if.out_last, stream_if.out_data}, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_word", {stream_if.out_last, stream_if.out_data}, e);
                    end
                end
                prev_stall = stream_if.out_valid && !stream_if.out_ready;
                prev_word  = {stream_if.out_last, stream_if.out_data};
            end
        end
    end

    // Run one message: start, stream len bytes, drain, and check the end state when it finishes with last.
    task automatic send_msg(input int len, input logic [31:0] init, input int rdy_pct,
                            input bit give_last, input int stall_at, input bit ff_data);
        int          k, cyc, stall_left, n_req0, exp_blocks;
        bit          acc, prev_acc, prev_blk_end;
        logic [8:0]  prev_exp;
        logic [32:0] fin;
        exp_base = init;
        req_idx  = 0;
        n_req0   = ks_req_cnt;
        @(negedge clk);
        init_counter = init;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("start_busy", busy, 1);
        chk("start_block_counter", block_counter, init);
        chk("wait_in_ready", stream_if.in_ready, 0);
        k = 0; cyc = 0; stall_left = 5; prev_acc = 0; prev_blk_end = 0; prev_exp = '0;
        while (k < len && cyc < len * 30 + 100) begin
            @(negedge clk);
            cyc++;
            if (prev_acc) begin
                chk("latency_valid", stream_if.out_valid, 1);
                chk("latency_word", {stream_if.out_last, stream_if.out_data}, prev_exp);
            end
            if (k >= stall_at && stall_at >= 0 && stall_left > 0) begin
                stream_if.out_ready = 1'b0;
                stream_if.in_valid  = 1'b1;
                stall_left--;
            end else begin
                stream_if.out_ready = ($urandom_range(0, 99) < rdy_pct);
                stream_if.in_valid  = ff_data || ($urandom_range(0, 3) != 0);
            end
            stream_if.in_data = ff_data ? 8'hFF : 8'($urandom);
            stream_if.in_last = give_last && (k == len - 1);
            #1;
            acc = stream_if.in_valid && stream_if.in_ready;
            if (prev_blk_end) chk("blk_end_in_ready", stream_if.in_ready, 0);
            prev_blk_end = 0;
            if (acc) begin
                prev_exp = {stream_if.in_last, stream_if.in_data ^ ks_mem[(k / NB) & 7][k % NB]};
                exp_q.push_back(prev_exp);
                prev_blk_end = ((k % NB) == NB - 1) && !stream_if.in_last;
                k++;
            end
            prev_acc = acc;
        end
        chk("bytes_sent", k, len);
        @(negedge clk);
        stream_if.in_valid = 1'b0;
        stream_if.in_last  = 1'b0;
        if (prev_acc) begin
            chk("latency_valid", stream_if.out_valid, 1);
            chk("latency_word", {stream_if.out_last, stream_if.out_data}, prev_exp);
        end
        stream_if.out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("drained", exp_q.size(), 0);
        if (give_last) begin
            exp_blocks = (len + NB - 1) / NB;
            fin = {1'b0, init} + 33'(exp_blocks);
            if (fin > 33'h0_FFFF_FFFF) fin = 33'h0_FFFF_FFFF;
            chk("end_busy", busy, 0);
            chk("end_block_counter", block_counter, fin[31:0]);
            chk("end_ks_reqs", ks_req_cnt - n_req0, exp_blocks);
            chk("end_ctr_overflow", ctr_overflow, 0);
        end
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n0;
        logic [31:0] c0;
        stream_if.in_valid  = 1'b0;
        stream_if.in_last   = 1'b0;
        stream_if.in_data   = '0;
        stream_if.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset("por");
        rst = 1'b1;

        // Incrementing keystream, all-0xFF data, last byte at offset 10 of the second block.
        ks_mode_incr = 1'b1;
        send_msg(75, 32'd1, 100, 1'b1, -1, 1'b1);
        ks_mode_incr = 1'b0;

        // Restart reloads init_counter; then a sink stall, exact block lengths, and a single byte.
        send_msg(20, 32'h1234_5678, 100, 1'b1, -1, 1'b0);
        send_msg(40, $urandom & 32'h7FFF_FFFF, 100, 1'b1, 10, 1'b0);
        send_msg(64, $urandom & 32'h7FFF_FFFF, 70, 1'b1, -1, 1'b0);
        send_msg(128, $urandom & 32'h7FFF_FFFF, 60, 1'b1, -1, 1'b0);
        send_msg(1, $urandom & 32'h7FFF_FFFF, 100, 1'b1, -1, 1'b0);
        send_msg(5, 32'hFFFF_FFFF, 80, 1'b1, -1, 1'b0);

        for (int m = 0; m < 6; m++)
            send_msg(int'($urandom_range(1, 200)), $urandom & 32'h7FFF_FFFF,
                     int'($urandom_range(40, 100)), 1'b1,
                     ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 100)) : -1, 1'b0);

        // Counter overflow at the end of a block moves to ERROR.
        n0 = ks_req_cnt;
        send_msg(64, 32'hFFFF_FFFF, 100, 1'b0, -1, 1'b0);
        @(negedge clk);
        #1;
        chk("ovf_flag", ctr_overflow, 1);
        chk("ovf_busy", busy, 1);
        chk("ovf_in_ready", stream_if.in_ready, 0);
        chk("ovf_block_counter", block_counter, 32'hFFFF_FFFF);
        chk("ovf_no_req", ks_req_cnt - n0, 1);
`ifdef CHACHA_KS_ZEROIZE_EN
        chk("ovf_zeroize", dut.ks_buf, '0);
`endif
        c0 = block_counter;
        @(negedge clk);
        init_counter = 32'h5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("err_start_ignored_req", ks_req_cnt - n0, 1);
        chk("err_start_ignored_ctr", block_counter, c0);
        chk("err_still_busy", busy, 1);
        chk("err_sticky", ctr_overflow, 1);
        @(negedge clk);
        #3 rst = 1'b0;
        #1 check_reset("ovf_rst");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;

        // Reset in the middle of a block, with idx at 30.
        send_msg(30, $urandom & 32'h7FFF_FFFF, 100, 1'b0, -1, 1'b0);
`ifdef CHACHA_KS_ZEROIZE_EN
        for (int i = 0; i < 30; i++) chk("zeroize_used_byte", dut.ks_buf[i], 0);
`endif
        @(negedge clk);
        #3 rst = 1'b0;
        #1 check_reset("mid_rst");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        send_msg(50, $urandom & 32'h7FFF_FFFF, 75, 1'b1, 20, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
